// File: rtl/fp16_frac_adder_arbiter.sv
// Round-robin shared 11-bit fraction adder: 2-stage pipeline, result valid one edge after accept.
// Full backpressure: a stalled response holds S2, S1 takes at most one more operand, then all grants drop.
module fp16_frac_adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*11-1:0]  req_a,
   input  logic [NUM_REQ*11-1:0]  req_b,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [11:0]            resp_sum,
   output logic [ID_W-1:0]        resp_id,
   output logic                   busy,
   output logic [15:0]            txn_count
);

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic            s1_valid_q, s1_valid_d;
   logic [10:0]     s1_a_q, s1_a_d;
   logic [10:0]     s1_b_q, s1_b_d;
   logic [ID_W-1:0] s1_id_q, s1_id_d;
   logic            s2_valid_q, s2_valid_d;
   logic [11:0]     s2_sum_q, s2_sum_d;
   logic [ID_W-1:0] s2_id_q, s2_id_d;
   logic [15:0]     txn_count_q, txn_count_d;

   logic            s2_adv, s1_adv, accept_ok, accept;
   logic            grant_found;
   logic [ID_W-1:0] grant_idx;
   int              scan_idx;
   logic [NUM_REQ-1:0] ready_c;
   logic [10:0]     sel_a, sel_b;
   logic [11:0]     fa_carry;
   logic [10:0]     fa_sum;
   logic [11:0]     add_res;

   assign s2_adv    = !s2_valid_q || resp_ready;
   assign s1_adv    = !s1_valid_q || s2_adv;
   assign accept_ok = s1_adv && rst_n;

   // Rotating priority search: first valid requester at or after rr_ptr wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(rr_ptr_q) + k;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      ready_c            = '0;
      ready_c[grant_idx] = accept_ok && grant_found;
   end

   assign req_ready = ready_c;
   assign accept    = accept_ok && grant_found;
   assign sel_a     = req_a[int'(grant_idx)*11 +: 11];
   assign sel_b     = req_b[int'(grant_idx)*11 +: 11];

   // Ripple-carry fraction adder on the S1 operands.
   assign fa_carry[0] = 1'b0;
   for (genvar g = 0; g < 11; g++) begin : g_fa
      assign fa_sum[g]     = s1_a_q[g] ^ s1_b_q[g] ^ fa_carry[g];
      assign fa_carry[g+1] = (s1_a_q[g] & s1_b_q[g]) | (fa_carry[g] & (s1_a_q[g] ^ s1_b_q[g]));
   end
   assign add_res = {fa_carry[11], fa_sum};

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_id_d     = s1_id_q;
      s2_valid_d  = s2_valid_q;
      s2_sum_d    = s2_sum_q;
      s2_id_d     = s2_id_q;
      txn_count_d = txn_count_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = sel_a;
         s1_b_d     = sel_b;
         s1_id_d    = grant_idx;
         rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_sum_d = add_res;
            s2_id_d  = s1_id_q;
         end
      end

      if (s2_valid_q && resp_ready) begin
         txn_count_d = txn_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_id_q     <= '0;
         s2_valid_q  <= 1'b0;
         s2_sum_q    <= '0;
         s2_id_q     <= '0;
         txn_count_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_id_q     <= s1_id_d;
         s2_valid_q  <= s2_valid_d;
         s2_sum_q    <= s2_sum_d;
         s2_id_q     <= s2_id_d;
         txn_count_q <= txn_count_d;
      end
   end

   assign resp_valid = s2_valid_q;
   assign resp_sum   = s2_sum_q;
   assign resp_id    = s2_id_q;
   assign busy       = s1_valid_q | s2_valid_q;
   assign txn_count  = txn_count_q;

endmodule

// File: tb/tb_fp16_frac_adder_arbiter.sv
// Scoreboard bench for fp16_frac_adder_arbiter: directed requests push hand-computed results,
// a negedge monitor pops and compares every response handshake and checks held data during stalls.
module tb_fp16_frac_adder_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [43:0] req_a;
   logic [43:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [11:0] resp_sum;
   logic [1:0]  resp_id;
   logic        busy;
   logic [15:0] txn_count;

   fp16_frac_adder_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_sum   (resp_sum),
      .resp_id    (resp_id),
      .busy       (busy),
      .txn_count  (txn_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] sum;
      logic [1:0]  id;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [10:0] opa[4];
   logic [10:0] opb[4];
   logic [11:0] fs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of requests, check the grant, and queue the expected result.
   task automatic step(input logic [3:0] vld, input logic [3:0] exp_rdy, input logic [11:0] exp_sum);
      exp_t e;
      req_valid = vld;
      req_a     = {opa[3], opa[2], opa[1], opa[0]};
      req_b     = {opb[3], opb[2], opb[1], opb[0]};
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_rdy != 4'b0000) begin
         e.sum = exp_sum;
         e.id  = 2'd0;
         for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) e.id = 2'(i);
         end
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input logic [15:0] exp_txn);
      bit done;
      done       = 1'b0;
      req_valid  = 4'b0000;
      resp_ready = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) done = 1'b1;
      end
      chk("drain_done", 32'(done), 32'd1);
      chk("txn_count", 32'(txn_count), 32'(exp_txn));
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_resp_sum", 32'(resp_sum), 32'hFFFF_FFFF);
         end else begin
            chk(resp_ready ? "resp_sum" : "stall_sum", 32'(resp_sum), 32'(sb[0].sum));
            chk(resp_ready ? "resp_id" : "stall_id", 32'(resp_id), 32'(sb[0].id));
            if (resp_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         opa[i] = '0;
         opb[i] = '0;
      end
      fs[0] = 12'h003; fs[1] = 12'h7FF; fs[2] = 12'h900; fs[3] = 12'h0FF;
      rst_n      = 1'b0;
      req_valid  = 4'b1111;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;

      // Reset state.
      @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_txn", 32'(txn_count), 32'd0);
      chk("rst_resp_sum", 32'(resp_sum), 32'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 4'b0000;

      // Single add with latency check.
      opa[2] = 11'h7FF; opb[2] = 11'h001;
      step(4'b0100, 4'b0100, 12'h800);
      req_valid = 4'b0000;
      @(negedge clk);
      chk("lat_s1_only", 32'(resp_valid), 32'd0);
      chk("lat_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("lat_resp_valid", 32'(resp_valid), 32'd1);
      @(posedge clk);
      #1;
      drain(16'd1);

      // Carry out and zero operands from requester 0, back to back.
      opa[0] = 11'h7FF; opb[0] = 11'h7FF;
      step(4'b0001, 4'b0001, 12'hFFE);
      opa[0] = 11'h000; opb[0] = 11'h000;
      step(4'b0001, 4'b0001, 12'h000);
      drain(16'd3);

      // Pointer at 1 with only 3 and 0 requesting: 3 wins, then 0, pointer ends at 1.
      opa[3] = 11'h123; opb[3] = 11'h456;
      opa[0] = 11'h400; opb[0] = 11'h400;
      opa[1] = 11'h555; opb[1] = 11'h2AA;
      step(4'b1001, 4'b1000, 12'h579);
      step(4'b1001, 4'b0001, 12'h800);
      step(4'b1111, 4'b0010, 12'h7FF);
      drain(16'd6);

      opa[3] = 11'h0F0; opb[3] = 11'h00F;
      step(4'b1000, 4'b1000, 12'h0FF);
      drain(16'd7);

      // Round-robin with everyone requesting.
      opa[0] = 11'h001; opb[0] = 11'h002;
      opa[2] = 11'h600; opb[2] = 11'h300;
      for (int k = 0; k < 8; k++) begin
         logic [3:0] oh;
         oh = 4'b0001 << (k % 4);
         step(4'b1111, oh, fs[k % 4]);
      end
      drain(16'd15);

      // Backpressure: two accepts fill the pipe, then grants stop while S2 holds.
      resp_ready = 1'b0;
      step(4'b1111, 4'b0001, 12'h003);
      step(4'b1111, 4'b0010, 12'h7FF);
      for (int k = 0; k < 3; k++) step(4'b1111, 4'b0000, 12'h000);
      drain(16'd17);

      // Reset with both stages full discards them and returns pointer to 0.
      resp_ready = 1'b0;
      step(4'b0110, 4'b0100, 12'h900);
      step(4'b0110, 4'b0010, 12'h7FF);
      rst_n = 1'b0;
      step(4'b1111, 4'b0000, 12'h000);
      sb.delete();
      rst_n      = 1'b1;
      req_valid  = 4'b0000;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_txn", 32'(txn_count), 32'd0);
      @(posedge clk);
      #1;
      step(4'b1111, 4'b0001, 12'h003);
      drain(16'd1);
      for (int k = 0; k < 5; k++) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fp16_frac_adder_arbiter.md
Name: fp16_frac_adder_arbiter

Overview:
- Shares one 11-bit fraction adder (ripple of full adders, 12-bit {carry,sum} result) among NUM_REQ requesters, e.g. the PE columns of the fp16 systolic adder path.
- Arbitrates with a round-robin scheme and accepts operands over a valid/ready handshake.
- Runs the add in a 2-stage pipeline with full backpressure.
- Returns the tagged result on one shared response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester tag; must equal clog2(NUM_REQ), with a minimum of 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*11  packed fractionA; requester i at bits [11*i+10 : 11*i].
- req_b  input  NUM_REQ*11  packed fractionB; same packing as req_a.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- resp_sum  output  12  {carry_out, sum[10:0]} of a+b.
- resp_id  output  ID_W  index of the requester that owns resp_sum.
- busy  output  1  high when either pipeline stage holds data.
- txn_count  output  16  number of completed response handshakes; wraps at 0xFFFF -> 0.

Behaviour:
- Reset, applied synchronously when rst_n=0 at a clock edge:
  - s1_valid=0, s2_valid=0, rr_ptr=0, txn_count=0.
  - resp_valid=0, resp_sum=0, resp_id=0, busy=0.
  - req_ready=0 during the reset cycle.
  - Reset mid-operation discards both in-flight transactions; no response is ever emitted for them.
- Pipeline:
  - S1 holds {a, b, id}.
  - S2 holds {sum, id}; S2 drives resp_*.
  - resp_valid = s2_valid.
- Advance conditions:
  - s2_adv = !s2_valid || resp_ready.
  - s1_adv = !s1_valid || s2_adv.
  - Accept is possible only when s1_adv=1 and rst_n=1.
- Arbitration (combinational, same cycle):
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1, only when accept is possible.
  - All other req_ready bits are 0.
  - req_ready never depends on req_valid of the granted requester other than through the search.
- Accept (req_valid[i] && req_ready[i]):
  - S1 captures a, b and id=i.
  - rr_ptr <= (i+1) mod NUM_REQ.
  - Without an accept, rr_ptr holds.
- S1->S2: when s1_valid && s2_adv, S2 captures sum = zero-extended a + b (12 bits, carry in bit 11) and id.
- S1 load/clear: s1_valid <= accept, and it is cleared only by advancing with no new accept.
- Latency and throughput:
  - Accept at edge T gives resp_valid=1 after edge T+1 when not stalled.
  - With resp_ready held high: 1 transaction per cycle, back-to-back.
- Stall:
  - When resp_valid && !resp_ready, S2 holds resp_sum and resp_id stable.
  - S1 holds if it is full.
  - If S1 is empty, one more accept fills it; after that all req_ready=0.
- Simultaneous events:
  - Response handshake and new accept in the same cycle are both legal; the pipeline shifts.
  - Handshake with s1_valid=0 clears s2_valid.
- Requester obligations: a requester that raises req_valid holds it and its operands until ready. The block does not require this for correctness, since it samples only at the handshake.
- busy = s1_valid | s2_valid.
- txn_count increments on each resp_valid && resp_ready.
- Grant is unaffected by which requester occupies the pipeline; the same requester may hold both stages.

Test Plan:
- Single add, no stall:
  - Stimulus: req 2 valid with a=0x7FF, b=0x001, resp_ready=1.
  - Response: req_ready[2] in the same cycle; 2 cycles later resp_valid=1, resp_sum=0x800, resp_id=2; txn_count=1.
- Carry and maximum:
  - Stimulus: req 0 with a=0x7FF, b=0x7FF; then a=0x000, b=0x000.
  - Response: resp_sum=0xFFE, then 0x000; ids 0, 0 on consecutive cycles.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high, resp_ready=1, for 8 accepts.
  - Response: grant order 0,1,2,3,0,1,2,3; one resp per cycle; resp_ids in the same order.
- Backpressure:
  - Stimulus: resp_ready=0 with requests pending.
  - Response: exactly 2 accepts, then req_ready=0; resp_sum/resp_id stable; after resp_ready=1, both results drain in order; no loss or duplication.
- Pointer skip:
  - Stimulus: rr_ptr=1 with only req 3 and req 0 valid.
  - Response: grant 3, then 0; rr_ptr goes 0, then 1.
- Reset mid-flight:
  - Stimulus: rst_n=0 for 1 cycle while both stages are full.
  - Response: resp_valid=0, busy=0, txn_count=0, rr_ptr=0; no stale response after reset releases.
